// File: rtl/player_motion.sv
// Per-frame sprite position controller: key decode, horizontal stepping with clamping,
// and a ground/rising/falling jump state machine with signed vertical velocity.
module player_motion #(
  parameter int          NKEYS     = 6,
  parameter logic [7:0]  KEY_LEFT  = 8'h04,
  parameter logic [7:0]  KEY_RIGHT = 8'h07,
  parameter logic [7:0]  KEY_JUMP  = 8'h1A,
  parameter int          X_CENTER  = 320,
  parameter int          Y_CENTER  = 240,
  parameter int          X_MIN     = 0,
  parameter int          X_MAX     = 639,
  parameter int          Y_MIN     = 0,
  parameter int          Y_MAX     = 479,
  parameter int          SIZE      = 4,
  parameter int          X_STEP    = 1,
  parameter int          JUMP_VEL  = 8,
  parameter int          GRAV      = 1,
  parameter int          MAX_FALL  = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode [NKEYS],
  input  logic       up,
  input  logic       left,
  input  logic       right,
  input  logic       down,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic [9:0] Size,
  output logic [9:0] VelY,
  output logic [1:0] State,
  output logic       Airborne
);

  typedef enum logic [1:0] {
    GROUND  = 2'b00,
    RISING  = 2'b01,
    FALLING = 2'b10
  } state_t;

  localparam logic signed [10:0] X_LO   = 11'(X_MIN + SIZE);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN + SIZE);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE);
  localparam logic signed [10:0] X_STP  = 11'(X_STEP);
  localparam logic signed [9:0]  V_JUMP = 10'(-JUMP_VEL);
  localparam logic signed [9:0]  V_GRAV = 10'(GRAV);
  localparam logic signed [9:0]  V_MAX  = 10'(MAX_FALL);

  state_t             state, state_nxt;
  logic [9:0]         pos_x, pos_x_nxt;
  logic [9:0]         pos_y, pos_y_nxt;
  logic signed [9:0]  vel_y, vel_y_nxt, vel_inc;
  logic               jump_armed, jump_armed_nxt;
  logic               key_l, key_r, key_j, launch;
  logic signed [10:0] x_cur, x_sum, y_sum;
  logic               hit_floor, hit_ceil;

  always_comb begin
    key_l = 1'b0;
    key_r = 1'b0;
    key_j = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (keycode[i] == KEY_LEFT)  key_l = 1'b1;
      if (keycode[i] == KEY_RIGHT) key_r = 1'b1;
      if (keycode[i] == KEY_JUMP)  key_j = 1'b1;
    end
  end

  // Horizontal: 11-bit signed arithmetic so stepping past either edge cannot wrap.
  always_comb begin
    x_cur = $signed({1'b0, pos_x});
    x_sum = x_cur;
    if (key_r && !key_l && !right) begin
      x_sum = x_cur + X_STP;
      if (x_sum > X_HI) x_sum = X_HI;
    end else if (key_l && !key_r && !left) begin
      x_sum = x_cur - X_STP;
      if (x_sum < X_LO) x_sum = X_LO;
    end
    pos_x_nxt = x_sum[9:0];
  end

  always_comb begin
    state_nxt = state;
    pos_y_nxt = pos_y;
    vel_y_nxt = vel_y;
    launch    = 1'b0;
    y_sum     = $signed({1'b0, pos_y}) + $signed({vel_y[9], vel_y});
    vel_inc   = vel_y + V_GRAV;
    hit_floor = (y_sum > Y_HI);
    hit_ceil  = (y_sum < Y_LO);

    // Collision flags win over the screen clamp, which wins over the normal update.
    case (state)
      GROUND: begin
        vel_y_nxt = '0;
        if (!down) begin
          state_nxt = FALLING;
        end else if (key_j && jump_armed) begin
          state_nxt = RISING;
          vel_y_nxt = V_JUMP;
          launch    = 1'b1;
        end
      end
      RISING, FALLING: begin
        if ((state == RISING) && up) begin
          state_nxt = FALLING;
          vel_y_nxt = '0;
        end else if ((state == FALLING) && down) begin
          state_nxt = GROUND;
          vel_y_nxt = '0;
        end else if (hit_floor) begin
          pos_y_nxt = Y_HI[9:0];
          state_nxt = GROUND;
          vel_y_nxt = '0;
        end else if (hit_ceil) begin
          pos_y_nxt = Y_LO[9:0];
          state_nxt = FALLING;
          vel_y_nxt = '0;
        end else begin
          pos_y_nxt = y_sum[9:0];
          if (state == RISING) begin
            vel_y_nxt = vel_inc;
            if (!vel_inc[9]) state_nxt = FALLING;
          end else begin
            vel_y_nxt = (vel_inc > V_MAX) ? V_MAX : vel_inc;
          end
        end
      end
      default: begin
        state_nxt = GROUND;
        vel_y_nxt = '0;
      end
    endcase

    // Re-arm needs a frame with the jump key released, so holding it never repeats.
    if (launch)      jump_armed_nxt = 1'b0;
    else if (!key_j) jump_armed_nxt = 1'b1;
    else             jump_armed_nxt = jump_armed;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= GROUND;
      pos_x      <= 10'(X_CENTER);
      pos_y      <= 10'(Y_CENTER);
      vel_y      <= '0;
      jump_armed <= 1'b1;
    end else begin
      state      <= state_nxt;
      pos_x      <= pos_x_nxt;
      pos_y      <= pos_y_nxt;
      vel_y      <= vel_y_nxt;
      jump_armed <= jump_armed_nxt;
    end
  end

  assign PosX     = pos_x;
  assign PosY     = pos_y;
  assign VelY     = vel_y;
  assign Size     = 10'(SIZE);
  assign State    = state;
  assign Airborne = (state != GROUND);

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: per-scenario tasks compared frame by frame against an
// integer reference model of the motion rules, plus fixed expected values for key frames.
module tb_player_motion;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode [6];
  logic       up, left, right, down;
  logic [9:0] PosX, PosY, Size, VelY;
  logic [1:0] State;
  logic       Airborne;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state in plain integers.
  int m_px, m_py, m_vy, m_st, m_armed;

  player_motion dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .up        (up),
    .left      (left),
    .right     (right),
    .down      (down),
    .PosX      (PosX),
    .PosY      (PosY),
    .Size      (Size),
    .VelY      (VelY),
    .State     (State),
    .Airborne  (Airborne)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic model_step();
    bit kl, kr, kj, launch;
    int s;
    kl = 0; kr = 0; kj = 0; launch = 0;
    foreach (keycode[i]) begin
      if (keycode[i] == 8'h04) kl = 1;
      if (keycode[i] == 8'h07) kr = 1;
      if (keycode[i] == 8'h1A) kj = 1;
    end
    if (Reset) begin
      m_px = 320; m_py = 240; m_vy = 0; m_st = 0; m_armed = 1;
      return;
    end
    if (kr && !kl && !right) m_px = (m_px + 1 > 635) ? 635 : m_px + 1;
    if (kl && !kr && !left)  m_px = (m_px - 1 < 4) ? 4 : m_px - 1;
    s = m_py + m_vy;
    case (m_st)
      0: begin
        if (!down) begin m_st = 2; m_vy = 0; end
        else if (kj && m_armed) begin m_st = 1; m_vy = -8; launch = 1; end
        else m_vy = 0;
      end
      1: begin
        if (up) begin m_st = 2; m_vy = 0; end
        else if (s > 475) begin m_py = 475; m_st = 0; m_vy = 0; end
        else if (s < 4) begin m_py = 4; m_st = 2; m_vy = 0; end
        else begin
          m_py = s;
          m_vy = m_vy + 1;
          if (m_vy >= 0) m_st = 2;
        end
      end
      default: begin
        if (down) begin m_st = 0; m_vy = 0; end
        else if (s > 475) begin m_py = 475; m_st = 0; m_vy = 0; end
        else if (s < 4) begin m_py = 4; m_st = 2; m_vy = 0; end
        else begin
          m_py = s;
          m_vy = (m_vy + 1 > 6) ? 6 : m_vy + 1;
        end
      end
    endcase
    if (launch) m_armed = 0;
    else if (!kj) m_armed = 1;
  endtask

  function automatic logic [32:0] model_vec();
    return {10'(m_px), 10'(m_py), 10'(m_vy), 2'(m_st), (m_st != 0)};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
  endtask

  task automatic clear_keys();
    foreach (keycode[i]) keycode[i] = 8'h00;
  endtask

  task automatic test_reset();
    Reset = 1; down = 1; up = 0; left = 0; right = 0;
    clear_keys();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (PosX !== 10'd320 || PosY !== 10'd240 || VelY !== 10'd0 || State !== 2'b00 || Airborne !== 1'b0) begin
        n_fail++;
        $display("FAIL reset f%0d: got x=%0d y=%0d v=%0d s=%0d a=%0d, want x=320 y=240 v=0 s=0 a=0",
                 i, PosX, PosY, $signed(VelY), State, Airborne);
      end
    end
    n_checks++;
    if (Size !== 10'd4) begin
      n_fail++;
      $display("FAIL size: got %0d, want 4", Size);
    end
    Reset = 0;
  endtask

  task automatic test_horizontal();
    keycode[5] = 8'h07;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (PosX !== 10'(321 + i) || {PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
        n_fail++;
        $display("FAIL move_right f%0d: got x=%0d y=%0d s=%0d, want x=%0d y=%0d s=%0d", i, PosX, PosY, State, 321 + i, m_py, m_st);
      end
    end
    right = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (PosX !== 10'd325) begin
        n_fail++;
        $display("FAIL right_blocked f%0d: got x=%0d, want x=325", i, PosX);
      end
    end
    right = 0;
    keycode[0] = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (PosX !== 10'd325) begin
        n_fail++;
        $display("FAIL both_keys f%0d: got x=%0d, want x=325", i, PosX);
      end
    end
    keycode[5] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (PosX !== 10'(324 - i)) begin
        n_fail++;
        $display("FAIL move_left f%0d: got x=%0d, want x=%0d", i, PosX, 324 - i);
      end
    end
    left = 1;
    tick();
    n_checks++;
    if (PosX !== 10'd323) begin
      n_fail++;
      $display("FAIL left_blocked: got x=%0d, want x=323", PosX);
    end
    left = 0;
    clear_keys();
  endtask

  task automatic test_jump();
    int ys [8] = '{232, 225, 219, 214, 210, 207, 205, 204};
    down = 1;
    keycode[2] = 8'h1A;
    tick();
    n_checks++;
    if (State !== 2'b01 || VelY !== 10'h3F8 || PosY !== 10'd240 || Airborne !== 1'b1) begin
      n_fail++;
      $display("FAIL launch: got y=%0d v=%0d s=%0d a=%0d, want y=240 v=-8 s=1 a=1", PosY, $signed(VelY), State, Airborne);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (PosY !== 10'(ys[i]) || {PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
        n_fail++;
        $display("FAIL rise f%0d: got y=%0d v=%0d s=%0d, want y=%0d v=%0d s=%0d", i, PosY, $signed(VelY), State, ys[i], m_vy, m_st);
      end
    end
    n_checks++;
    if (State !== 2'b10 || VelY !== 10'd0) begin
      n_fail++;
      $display("FAIL apex: got v=%0d s=%0d, want v=0 s=2", $signed(VelY), State);
    end
    tick();
    n_checks++;
    if (State !== 2'b00 || PosY !== 10'd204) begin
      n_fail++;
      $display("FAIL land: got y=%0d s=%0d, want y=204 s=0", PosY, State);
    end
    clear_keys();
    tick();
  endtask

  task automatic test_fall();
    int y;
    y = 204;
    down = 0;
    tick();
    n_checks++;
    if (State !== 2'b10 || VelY !== 10'd0 || PosY !== 10'(y)) begin
      n_fail++;
      $display("FAIL fall_start: got y=%0d v=%0d s=%0d, want y=%0d v=0 s=2", PosY, $signed(VelY), State, y);
    end
    for (int k = 1; k <= 8; k++) begin
      y = y + ((k - 1 > 6) ? 6 : k - 1);
      tick();
      n_checks++;
      if (VelY !== 10'((k > 6) ? 6 : k) || PosY !== 10'(y) || {PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
        n_fail++;
        $display("FAIL fall f%0d: got y=%0d v=%0d, want y=%0d v=%0d", k, PosY, $signed(VelY), y, (k > 6) ? 6 : k);
      end
    end
    down = 1;
    tick();
    n_checks++;
    if (State !== 2'b00 || VelY !== 10'd0 || PosY !== 10'(y)) begin
      n_fail++;
      $display("FAIL fall_land: got y=%0d v=%0d s=%0d, want y=%0d v=0 s=0", PosY, $signed(VelY), State, y);
    end
  endtask

  task automatic test_ceiling();
    keycode[2] = 8'h1A;
    tick();
    tick();
    tick();
    up = 1;
    tick();
    n_checks++;
    if (State !== 2'b10 || VelY !== 10'd0 || PosY !== 10'd216 || {PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
      n_fail++;
      $display("FAIL ceiling: got y=%0d v=%0d s=%0d, want y=216 v=0 s=2", PosY, $signed(VelY), State);
    end
    up = 0;
    clear_keys();
    tick();
    tick();
  endtask

  task automatic test_jump_hold();
    keycode[1] = 8'h1A;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if ({PosX, PosY, VelY, State, Airborne} !== model_vec() || (i >= 10 && State !== 2'b00)) begin
        n_fail++;
        $display("FAIL hold f%0d: got y=%0d v=%0d s=%0d, want y=%0d v=%0d s=%0d", i, PosY, $signed(VelY), State, m_py, m_vy, m_st);
      end
    end
    clear_keys();
    tick();
    keycode[4] = 8'h1A;
    tick();
    n_checks++;
    if (State !== 2'b01 || VelY !== 10'h3F8) begin
      n_fail++;
      $display("FAIL relaunch: got v=%0d s=%0d, want v=-8 s=1", $signed(VelY), State);
    end
    tick();
    tick();
    clear_keys();
    Reset = 1;
    tick();
    n_checks++;
    if (PosX !== 10'd320 || PosY !== 10'd240 || VelY !== 10'd0 || State !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset: got x=%0d y=%0d v=%0d s=%0d, want x=320 y=240 v=0 s=0", PosX, PosY, $signed(VelY), State);
    end
    Reset = 0;
  endtask

  task automatic test_clamps();
    bit seen;
    down = 1;
    keycode[0] = 8'h07;
    for (int i = 0; i < 330; i++) begin
      tick();
      n_checks++;
      if ({PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
        n_fail++;
        $display("FAIL clamp_right f%0d: got x=%0d, want x=%0d", i, PosX, m_px);
      end
    end
    n_checks++;
    if (PosX !== 10'd635) begin n_fail++; $display("FAIL x_max: got x=%0d, want x=635", PosX); end
    keycode[0] = 8'h04;
    for (int i = 0; i < 640; i++) begin
      tick();
      n_checks++;
      if ({PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
        n_fail++;
        $display("FAIL clamp_left f%0d: got x=%0d, want x=%0d", i, PosX, m_px);
      end
    end
    n_checks++;
    if (PosX !== 10'd4) begin n_fail++; $display("FAIL x_min: got x=%0d, want x=4", PosX); end
    clear_keys();
    down = 0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (PosY == 10'd475 && State == 2'b00) seen = 1;
      n_checks++;
      if ({PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
        n_fail++;
        $display("FAIL floor f%0d: got y=%0d v=%0d s=%0d, want y=%0d v=%0d s=%0d", i, PosY, $signed(VelY), State, m_py, m_vy, m_st);
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL floor_clamp: got no frame at y=475 grounded, want one within 60 frames"); end
    down = 1;
    seen = 0;
    for (int j = 0; j < 16; j++) begin
      keycode[3] = 8'h1A;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (PosY == 10'd4 && State == 2'b10) seen = 1;
        n_checks++;
        if ({PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
          n_fail++;
          $display("FAIL climb j%0d f%0d: got y=%0d v=%0d s=%0d, want y=%0d v=%0d s=%0d", j, i, PosY, $signed(VelY), State, m_py, m_vy, m_st);
        end
      end
      clear_keys();
      tick();
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL ceil_clamp: got no frame at y=4 falling, want one within 16 jumps"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      foreach (keycode[k]) begin
        case ($urandom_range(0, 9))
          0: keycode[k] = 8'h04;
          1: keycode[k] = 8'h07;
          2: keycode[k] = 8'h1A;
          3: keycode[k] = 8'($urandom);
          default: keycode[k] = 8'h00;
        endcase
      end
      down  = ($urandom_range(0, 3) != 0);
      up    = ($urandom_range(0, 7) == 0);
      left  = ($urandom_range(0, 7) == 0);
      right = ($urandom_range(0, 7) == 0);
      Reset = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if ({PosX, PosY, VelY, State, Airborne} !== model_vec()) begin
        n_fail++;
        $display("FAIL random f%0d: got x=%0d y=%0d v=%0d s=%0d, want x=%0d y=%0d v=%0d s=%0d",
                 i, PosX, PosY, $signed(VelY), State, m_px, m_py, m_vy, m_st);
      end
    end
    Reset = 0;
  endtask

  initial begin
    m_px = 320; m_py = 240; m_vy = 0; m_st = 0; m_armed = 1;
    test_reset();
    test_horizontal();
    test_jump();
    test_fall();
    test_ceiling();
    test_jump_hold();
    test_clamps();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
